multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Multicycle successor to the single-cycle main decoder of the ARMv4 core. A registered state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and muxes from the current state. It adds a memory-ready handshake with a parametrised wait-state timeout and a sticky fault for stalled memory or an unsupported opcode. It sits in the controller beside the ALU decoder and condition logic.

Parameters:
- USE_MEM_READY, 1: 1 = memory states wait for memReady; 0 = memReady is ignored and treated as 1.
- MEM_TIMEOUT, 15: maximum number of wait cycles in one memory state before entering FAULT. Range 1..255.
- CNT_W, 8: width of the wait counter. Must be at least clog2(MEM_TIMEOUT+1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  2  instr[27:26]: 00 = data processing, 01 = memory, 10 = branch, 11 = unsupported.
- func5  in  1  instr[25], the I bit: immediate operand for DP; register-offset flag for memory.
- func0  in  1  instr[20], the S/L bit: for memory, 1 = LDR and 0 = STR.
- memReady  in  1  memory done/ack for the current access.
- pcW  out  1  PC write enable.
- irW  out  1  instruction-register write enable.
- regW  out  1  register-file write.
- memW  out  1  data-memory write.
- adrSrc  out  1  0 = PC address, 1 = ALU-result address.
- aluSrcA  out  1  0 = register A, 1 = PC.
- aluSrcB  out  2  00 = register, 01 = immediate, 10 = constant 4.
- resultSrc  out  2  00 = ALUOut, 01 = data, 10 = ALU direct.
- aluOp  out  1  1 = ALU decoder uses funct; 0 = add.
- branch  out  1  branch state: PC is taken if the condition passes.
- immSrc  out  2  equal to op.
- regSrc  out  2  bit0 = (op==10), bit1 = (op==01).
- fault  out  1  sticky error flag.
- state  out  4  current state, for debug and the bench.

Behaviour:
- States and encodings (in shared package):
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, FAULT = 15.
- Outputs are Moore: decoded from the registered state, plus memReady where noted. There are no outputs from unregistered op decode except immSrc and regSrc, which are combinational from op.
- Reset:
  - rst=1 at a clock edge sets state to FETCH, the wait counter to 0 and fault to 0.
  - While rst=1, pcW, irW, regW, memW and branch are forced to 0, and the other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no write strobe is asserted on that cycle.
- Transitions:
  - FETCH -> DECODE when ready.
  - DECODE routes by op: 01 -> MEMADR; 00 -> EXECI if func5=1, else EXECR; 10 -> BRANCH; 11 -> FAULT.
  - MEMADR -> MEMRD if func0=1, else MEMWR.
  - MEMRD -> MEMWB when ready. MEMWB -> FETCH.
  - MEMWR -> FETCH when ready.
  - EXECR and EXECI -> ALUWB. ALUWB -> FETCH. BRANCH -> FETCH.
  - FAULT stays in FAULT until rst.
- "ready" = memReady, or 1 when USE_MEM_READY=0.
- Wait counter:
  - In FETCH, MEMRD and MEMWR, the counter increments each cycle ready=0.
  - It clears on leaving the state.
  - If the counter equals MEM_TIMEOUT and ready=0, the next state is FAULT.
  - If ready=1 on that same cycle, ready wins and the FSM advances normally.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: adrSrc=0, aluSrcA=1, aluSrcB=10, resultSrc=10; irW=ready and pcW=ready (enables only on the completing cycle).
  - DECODE: aluSrcA=1, aluSrcB=10, resultSrc=10 (PC+8 read).
  - MEMADR: aluSrcB=01.
  - MEMRD: adrSrc=1.
  - MEMWB: resultSrc=01, regW=1.
  - MEMWR: adrSrc=1, memW=1. memW is held until ready.
  - EXECR: aluOp=1.
  - EXECI: aluSrcB=01, aluOp=1.
  - ALUWB: resultSrc=00, regW=1.
  - BRANCH: aluSrcB=01, resultSrc=10, branch=1.
  - FAULT: all strobes 0, fault=1.
- Latencies at zero wait: DP 4 cycles, LDR 5, STR 4, B 3.

Decomposition:
- Package ctrl_pkg:
  - state enum, 4-bit;
  - op constants OP_DP, OP_MEM, OP_BR;
  - aluSrcB and resultSrc encodings.
- Sub-module mem_wait_timer (counter plus timeout compare, parametrised by MEM_TIMEOUT and CNT_W), instantiated once.
- The FSM next-state and output decode stay in the top block.

Test Plan:
1. Reset hold, then DP register instruction (op=00, func5=0), memReady=1 → state sequence 0,1,6,8,0. irW and pcW are 1 only in FETCH; regW is 1 only in ALUWB.
2. LDR (op=01, func0=1), memReady low for 3 cycles in MEMRD → state 3 held for 4 cycles, then MEMWB with regW=1 and resultSrc=01. Total is 8 cycles.
3. STR with func5=1, memReady=1 → states 0,1,2,5,0. memW=1 for exactly 1 cycle with adrSrc=1.
4. Branch (op=10) → states 0,1,9,0. branch=1 for one cycle with aluSrcB=01.
5. With MEM_TIMEOUT=3, hold memReady=0 in FETCH → after 4 wait cycles the state becomes FAULT and fault=1. It stays there with no strobes until rst; after rst, state=0 and fault=0.
6. op=11 → DECODE goes to FAULT. Also: assert rst during MEMWR → memW=0 on that cycle and state=FETCH on the next cycle. With USE_MEM_READY=0, memReady=0 is ignored and the DP instruction completes in 4 cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StFault  = 4'd15
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles in a memory-handshake state and flags a timeout.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q;

    // Count while stalled; any completion or leaving the state clears the count.
    always_ff @(posedge clk) begin
        if (rst || !active || ready) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Ready on the boundary cycle wins over the timeout.
    assign timeout = active && !ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 15,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] op,
    input  logic       func5,
    input  logic       func0,
    input  logic       memReady,
    output logic       pcW,
    output logic       irW,
    output logic       regW,
    output logic       memW,
    output logic       adrSrc,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] resultSrc,
    output logic       aluOp,
    output logic       branch,
    output logic [1:0] immSrc,
    output logic [1:0] regSrc,
    output logic       fault,
    output logic [3:0] state
);

    state_e state_q;
    state_e dec_state;
    logic   fault_q;
    logic   ready;
    logic   wait_state;
    logic   timeout;

    assign ready      = USE_MEM_READY ? memReady : 1'b1;
    assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .active (wait_state),
        .ready  (ready),
        .timeout(timeout)
    );

    // State register and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (ready) begin
                        state_q <= StDecode;
                    end else if (timeout) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StDecode: begin
                    unique case (op)
                        OP_MEM:  state_q <= StMemAdr;
                        OP_DP:   state_q <= func5 ? StExecI : StExecR;
                        OP_BR:   state_q <= StBranch;
                        default: begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end
                    endcase
                end
                StMemAdr: state_q <= func0 ? StMemRd : StMemWr;
                StMemRd: begin
                    if (ready) begin
                        state_q <= StMemWb;
                    end else if (timeout) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StMemWb: state_q <= StFetch;
                StMemWr: begin
                    if (ready) begin
                        state_q <= StFetch;
                    end else if (timeout) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StExecR, StExecI: state_q <= StAluWb;
                StAluWb, StBranch: state_q <= StFetch;
                default: begin
                    state_q <= StFault;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    // Moore output decode; reset shows FETCH mux settings with all strobes off.
    always_comb begin
        pcW       = 1'b0;
        irW       = 1'b0;
        regW      = 1'b0;
        memW      = 1'b0;
        adrSrc    = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = SRCB_REG;
        resultSrc = RES_ALUOUT;
        aluOp     = 1'b0;
        branch    = 1'b0;
        dec_state = rst ? StFetch : state_q;
        unique case (dec_state)
            StFetch: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                irW       = ready && !rst;
                pcW       = ready && !rst;
            end
            StDecode: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
            end
            StMemAdr: aluSrcB = SRCB_IMM;
            StMemRd:  adrSrc = 1'b1;
            StMemWb: begin
                resultSrc = RES_DATA;
                regW      = 1'b1;
            end
            StMemWr: begin
                adrSrc = 1'b1;
                memW   = 1'b1;
            end
            StExecR:  aluOp = 1'b1;
            StExecI: begin
                aluSrcB = SRCB_IMM;
                aluOp   = 1'b1;
            end
            StAluWb: begin
                resultSrc = RES_ALUOUT;
                regW      = 1'b1;
            end
            StBranch: begin
                aluSrcB   = SRCB_IMM;
                resultSrc = RES_ALU;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign immSrc = op;
    assign regSrc = {op == OP_MEM, op == OP_BR};
    assign fault  = fault_q;
    assign state  = state_q;

endmodule
